// File: rtl/rename_reg_file.sv
// Architectural register file with per-register ROB rename labels (x0 hardwired to zero).
// Optional macro RF_BYPASS_EN forwards a same-cycle matching commit onto the read ports.
module rename_reg_file #(
  parameter int REG_NUM      = 32,
  parameter int VAL_WIDTH    = 32,
  parameter int ROB_ID_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n_in,
  input  logic                    rdy_in,
  input  logic                    dec_en,
  input  logic [4:0]              dec_rd,
  input  logic [ROB_ID_WIDTH:0]   dec_tag,
  input  logic [4:0]              rs1,
  input  logic [4:0]              rs2,
  output logic [ROB_ID_WIDTH:0]   rf_label1,
  output logic [ROB_ID_WIDTH:0]   rf_label2,
  output logic [VAL_WIDTH-1:0]    rf_val1,
  output logic [VAL_WIDTH-1:0]    rf_val2,
  input  logic                    commit_en,
  input  logic [4:0]              commit_rd,
  input  logic [VAL_WIDTH-1:0]    commit_res,
  input  logic [ROB_ID_WIDTH:0]   commit_lab,
  input  logic                    flush_in
);

  logic [VAL_WIDTH-1:0]  val_q   [REG_NUM];
  logic [VAL_WIDTH-1:0]  val_d   [REG_NUM];
  logic [ROB_ID_WIDTH:0] label_q [REG_NUM];
  logic [ROB_ID_WIDTH:0] label_d [REG_NUM];

  // Next-state: commit writes value and retires a matching label; issue (or flush) then overrides the label.
  always_comb begin
    for (int i = 0; i < REG_NUM; i++) begin
      val_d[i]   = val_q[i];
      label_d[i] = label_q[i];
      if (i == 0) begin
        val_d[i]   = '0;
        label_d[i] = '0;
      end else if (rdy_in) begin
        if (commit_en && (commit_rd == 5'(i))) begin
          val_d[i] = commit_res;
          if (label_q[i] == commit_lab) begin
            label_d[i] = '0;
          end else begin
            label_d[i] = label_q[i];
          end
        end else begin
          val_d[i] = val_q[i];
        end
        if (flush_in) begin
          label_d[i] = '0;
        end else if (dec_en && (dec_rd == 5'(i))) begin
          label_d[i] = dec_tag;
        end else begin
          label_d[i] = label_d[i];
        end
      end else begin
        val_d[i]   = val_q[i];
        label_d[i] = label_q[i];
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        val_q[i]   <= '0;
        label_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REG_NUM; i++) begin
        val_q[i]   <= val_d[i];
        label_q[i] <= label_d[i];
      end
    end
  end

  // Read ports: pre-edge state, x0 reads as zero, optional commit forwarding.
  always_comb begin
    rf_label1 = '0;
    rf_val1   = '0;
    rf_label2 = '0;
    rf_val2   = '0;
    if (rs1 != 5'd0) begin
      rf_label1 = label_q[rs1];
      rf_val1   = val_q[rs1];
    end else begin
      rf_label1 = '0;
      rf_val1   = '0;
    end
    if (rs2 != 5'd0) begin
      rf_label2 = label_q[rs2];
      rf_val2   = val_q[rs2];
    end else begin
      rf_label2 = '0;
      rf_val2   = '0;
    end
`ifdef RF_BYPASS_EN
    if (rdy_in && commit_en && (commit_rd != 5'd0) && (rs1 == commit_rd) &&
        (label_q[rs1] == commit_lab)) begin
      rf_label1 = '0;
      rf_val1   = commit_res;
    end else begin
      rf_label1 = rf_label1;
    end
    if (rdy_in && commit_en && (commit_rd != 5'd0) && (rs2 == commit_rd) &&
        (label_q[rs2] == commit_lab)) begin
      rf_label2 = '0;
      rf_val2   = commit_res;
    end else begin
      rf_label2 = rf_label2;
    end
`endif
  end

endmodule

// File: tb/tb_rename_reg_file.sv
// Self-checking bench for rename_reg_file: directed vector table, hand corner cases, random phase vs. a reference model.
module tb_rename_reg_file;

  logic        clk = 1'b0;
  logic        rst_n_in, rdy_in, dec_en, commit_en, flush_in;
  logic [4:0]  dec_rd, dec_tag, rs1, rs2, commit_rd, commit_lab;
  logic [4:0]  rf_label1, rf_label2;
  logic [31:0] rf_val1, rf_val2, commit_res;

  rename_reg_file #(.REG_NUM(32), .VAL_WIDTH(32), .ROB_ID_WIDTH(4)) dut (
    .clk(clk), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .dec_en(dec_en), .dec_rd(dec_rd), .dec_tag(dec_tag),
    .rs1(rs1), .rs2(rs2),
    .rf_label1(rf_label1), .rf_label2(rf_label2),
    .rf_val1(rf_val1), .rf_val2(rf_val2),
    .commit_en(commit_en), .commit_rd(commit_rd), .commit_res(commit_res),
    .commit_lab(commit_lab), .flush_in(flush_in)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  l1;
    logic [31:0] v1;
    logic [4:0]  l2;
    logic [31:0] v2;
  } exp_t;

  typedef struct packed {
    logic        rdy, de;
    logic [4:0]  drd, dtag;
    logic        ce;
    logic [4:0]  crd;
    logic [31:0] cres;
    logic [4:0]  clab;
    logic        fl;
    logic [4:0]  r1, r2;
    exp_t        e;
  } vec_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  vec_t        tbl[27];
  logic [31:0] m_val[32];
  logic [4:0]  m_lab[32];

  function automatic vec_t mk(input logic rdy, input logic de, input logic [4:0] drd, input logic [4:0] dtag,
                              input logic ce, input logic [4:0] crd, input logic [31:0] cres, input logic [4:0] clab,
                              input logic fl, input logic [4:0] r1, input logic [4:0] r2,
                              input logic [4:0] l1, input logic [31:0] v1, input logic [4:0] l2, input logic [31:0] v2);
    vec_t v;
    v.rdy = rdy; v.de = de; v.drd = drd; v.dtag = dtag;
    v.ce = ce; v.crd = crd; v.cres = cres; v.clab = clab;
    v.fl = fl; v.r1 = r1; v.r2 = r2;
    v.e.l1 = l1; v.e.v1 = v1; v.e.l2 = l2; v.e.v2 = v2;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rdy_in = v.rdy; dec_en = v.de; dec_rd = v.drd; dec_tag = v.dtag;
    commit_en = v.ce; commit_rd = v.crd; commit_res = v.cres; commit_lab = v.clab;
    flush_in = v.fl; rs1 = v.r1; rs2 = v.r2;
  endtask

  task automatic check_out(input string nm);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty, no expected value", nm);
      return;
    end
    e = sb.pop_front();
    if ({rf_label1, rf_val1, rf_label2, rf_val2} !== e) begin
      failures++;
      $display("FAIL %s: got l1=%0d v1=%h l2=%0d v2=%h required l1=%0d v1=%h l2=%0d v2=%h",
               nm, rf_label1, rf_val1, rf_label2, rf_val2, e.l1, e.v1, e.l2, e.v2);
    end
  endtask

  function automatic exp_t model_read();
    exp_t e;
    e.l1 = (rs1 != 5'd0) ? m_lab[rs1] : 5'd0;
    e.v1 = (rs1 != 5'd0) ? m_val[rs1] : 32'd0;
    e.l2 = (rs2 != 5'd0) ? m_lab[rs2] : 5'd0;
    e.v2 = (rs2 != 5'd0) ? m_val[rs2] : 32'd0;
`ifdef RF_BYPASS_EN
    if (rdy_in && commit_en && commit_rd != 5'd0 && rs1 == commit_rd && m_lab[rs1] == commit_lab) begin
      e.l1 = 5'd0; e.v1 = commit_res;
    end
    if (rdy_in && commit_en && commit_rd != 5'd0 && rs2 == commit_rd && m_lab[rs2] == commit_lab) begin
      e.l2 = 5'd0; e.v2 = commit_res;
    end
`endif
    return e;
  endfunction

  task automatic model_edge();
    if (rdy_in) begin
      if (commit_en && commit_rd != 5'd0) begin
        m_val[commit_rd] = commit_res;
        if (m_lab[commit_rd] == commit_lab) m_lab[commit_rd] = 5'd0;
      end
      if (flush_in) begin
        for (int k = 0; k < 32; k++) m_lab[k] = 5'd0;
      end else if (dec_en && dec_rd != 5'd0) begin
        m_lab[dec_rd] = dec_tag;
      end
    end
  endtask

  task automatic step(input vec_t v, input string nm);
    @(negedge clk);
    drive(v);
    sb.push_back(v.e);
    #1;
    check_out(nm);
  endtask

  initial begin
    exp_t e;
    //                rdy de drd    dtag   ce crd    cres          clab   fl r1     r2       l1     v1            l2     v2
    tbl[0]  = mk(1'b1,1'b0,5'd0, 5'd0, 1'b0,5'd0, 32'h0,      5'd0, 1'b0,5'd5, 5'd0,   5'd0, 32'h0,      5'd0, 32'h0);
    tbl[1]  = mk(1'b1,1'b1,5'd3, 5'd2, 1'b0,5'd0, 32'h0,      5'd0, 1'b0,5'd3, 5'd0,   5'd0, 32'h0,      5'd0, 32'h0);
    tbl[2]  = mk(1'b1,1'b0,5'd0, 5'd0, 1'b0,5'd0, 32'h0,      5'd0, 1'b0,5'd3, 5'd0,   5'd2, 32'h0,      5'd0, 32'h0);
    tbl[3]  = mk(1'b1,1'b0,5'd0, 5'd0, 1'b1,5'd3, 32'h1234,   5'd2, 1'b0,5'd0, 5'd0,   5'd0, 32'h0,      5'd0, 32'h0);
    tbl[4]  = mk(1'b1,1'b0,5'd0, 5'd0, 1'b0,5'd0, 32'h0,      5'd0, 1'b0,5'd3, 5'd0,   5'd0, 32'h1234,   5'd0, 32'h0);
    tbl[5]  = mk(1'b1,1'b1,5'd4, 5'd1, 1'b0,5'd0, 32'h0,      5'd0, 1'b0,5'd0, 5'd0,   5'd0, 32'h0,      5'd0, 32'h0);
    tbl[6]  = mk(1'b1,1'b1,5'd4, 5'd5, 1'b0,5'd0, 32'h0,      5'd0, 1'b0,5'd4, 5'd0,   5'd1, 32'h0,      5'd0, 32'h0);
    tbl[7]  = mk(1'b1,1'b0,5'd0, 5'd0, 1'b1,5'd4, 32'h7,      5'd1, 1'b0,5'd4, 5'd0,   5'd5, 32'h0,      5'd0, 32'h0);
    tbl[8]  = mk(1'b1,1'b0,5'd0, 5'd0, 1'b0,5'd0, 32'h0,      5'd0, 1'b0,5'd4, 5'd3,   5'd5, 32'h7,      5'd0, 32'h1234);
    tbl[9]  = mk(1'b1,1'b1,5'd6, 5'd3, 1'b0,5'd0, 32'h0,      5'd0, 1'b0,5'd0, 5'd0,   5'd0, 32'h0,      5'd0, 32'h0);
    tbl[10] = mk(1'b1,1'b1,5'd6, 5'd8, 1'b1,5'd6, 32'h9,      5'd3, 1'b0,5'd0, 5'd4,   5'd0, 32'h0,      5'd5, 32'h7);
    tbl[11] = mk(1'b1,1'b0,5'd0, 5'd0, 1'b0,5'd0, 32'h0,      5'd0, 1'b0,5'd6, 5'd0,   5'd8, 32'h9,      5'd0, 32'h0);
    tbl[12] = mk(1'b1,1'b1,5'd1, 5'd6, 1'b0,5'd0, 32'h0,      5'd0, 1'b0,5'd0, 5'd0,   5'd0, 32'h0,      5'd0, 32'h0);
    tbl[13] = mk(1'b1,1'b1,5'd2, 5'd7, 1'b0,5'd0, 32'h0,      5'd0, 1'b0,5'd0, 5'd0,   5'd0, 32'h0,      5'd0, 32'h0);
    tbl[14] = mk(1'b1,1'b1,5'd7, 5'd10,1'b0,5'd0, 32'h0,      5'd0, 1'b0,5'd0, 5'd0,   5'd0, 32'h0,      5'd0, 32'h0);
    tbl[15] = mk(1'b1,1'b0,5'd0, 5'd0, 1'b0,5'd0, 32'h0,      5'd0, 1'b0,5'd1, 5'd7,   5'd6, 32'h0,      5'd10,32'h0);
    tbl[16] = mk(1'b1,1'b1,5'd9, 5'd4, 1'b1,5'd1, 32'hAA,     5'd6, 1'b1,5'd2, 5'd9,   5'd7, 32'h0,      5'd0, 32'h0);
    tbl[17] = mk(1'b1,1'b0,5'd0, 5'd0, 1'b0,5'd0, 32'h0,      5'd0, 1'b0,5'd1, 5'd2,   5'd0, 32'hAA,     5'd0, 32'h0);
    tbl[18] = mk(1'b1,1'b0,5'd0, 5'd0, 1'b0,5'd0, 32'h0,      5'd0, 1'b0,5'd7, 5'd9,   5'd0, 32'h0,      5'd0, 32'h0);
    tbl[19] = mk(1'b1,1'b0,5'd0, 5'd0, 1'b0,5'd0, 32'h0,      5'd0, 1'b0,5'd6, 5'd4,   5'd0, 32'h9,      5'd0, 32'h7);
    tbl[20] = mk(1'b1,1'b1,5'd0, 5'd3, 1'b1,5'd0, 32'hDEAD,   5'd0, 1'b0,5'd0, 5'd0,   5'd0, 32'h0,      5'd0, 32'h0);
    tbl[21] = mk(1'b1,1'b0,5'd0, 5'd0, 1'b0,5'd0, 32'h0,      5'd0, 1'b0,5'd0, 5'd3,   5'd0, 32'h0,      5'd0, 32'h1234);
    tbl[22] = mk(1'b1,1'b1,5'd5, 5'd2, 1'b0,5'd0, 32'h0,      5'd0, 1'b0,5'd0, 5'd0,   5'd0, 32'h0,      5'd0, 32'h0);
    tbl[23] = mk(1'b0,1'b1,5'd3, 5'd9, 1'b1,5'd5, 32'hBEEF,   5'd2, 1'b1,5'd5, 5'd3,   5'd2, 32'h0,      5'd0, 32'h1234);
    tbl[24] = mk(1'b1,1'b0,5'd0, 5'd0, 1'b0,5'd0, 32'h0,      5'd0, 1'b0,5'd5, 5'd3,   5'd2, 32'h0,      5'd0, 32'h1234);
    tbl[25] = mk(1'b1,1'b0,5'd0, 5'd0, 1'b1,5'd5, 32'h55,     5'd2, 1'b0,5'd0, 5'd0,   5'd0, 32'h0,      5'd0, 32'h0);
    tbl[26] = mk(1'b1,1'b0,5'd0, 5'd0, 1'b0,5'd0, 32'h0,      5'd0, 1'b0,5'd5, 5'd0,   5'd0, 32'h55,     5'd0, 32'h0);

    rst_n_in = 1'b0;
    drive(mk(1'b1,1'b0,5'd0,5'd0,1'b0,5'd0,32'h0,5'd0,1'b0,5'd5,5'd0,5'd0,32'h0,5'd0,32'h0));
    repeat (2) @(negedge clk);
    e = '0;
    sb.push_back(e);
    #1 check_out("in_reset");
    rst_n_in = 1'b1;

    for (int i = 0; i < 27; i++) step(tbl[i], $sformatf("row%0d", i));

    // Same-cycle commit with rs1 == commit_rd and matching label.
    step(mk(1'b1,1'b1,5'd2,5'd3,1'b0,5'd0,32'h0,5'd0,1'b0,5'd0,5'd0,5'd0,32'h0,5'd0,32'h0), "byp_issue");
`ifdef RF_BYPASS_EN
    step(mk(1'b1,1'b0,5'd0,5'd0,1'b1,5'd2,32'h55,5'd3,1'b0,5'd2,5'd2,5'd0,32'h55,5'd0,32'h55), "byp_same_cycle");
`else
    step(mk(1'b1,1'b0,5'd0,5'd0,1'b1,5'd2,32'h55,5'd3,1'b0,5'd2,5'd2,5'd3,32'h0,5'd3,32'h0), "byp_same_cycle");
`endif
    step(mk(1'b1,1'b0,5'd0,5'd0,1'b0,5'd0,32'h0,5'd0,1'b0,5'd2,5'd5,5'd0,32'h55,5'd0,32'h55), "byp_after");

    // Asynchronous reset between clock edges.
    step(mk(1'b1,1'b1,5'd8,5'd12,1'b0,5'd0,32'h0,5'd0,1'b0,5'd5,5'd2,5'd0,32'h55,5'd0,32'h55), "pre_async");
    @(negedge clk);
    drive(mk(1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,32'h0,5'd0,1'b0,5'd8,5'd5,5'd0,32'h0,5'd0,32'h0));
    sb.push_back({5'd12, 32'h0, 5'd0, 32'h55});
    #1 check_out("label_before_async");
    #1 rst_n_in = 1'b0;
    e = '0;
    sb.push_back(e);
    #1 check_out("async_reset");
    @(negedge clk);
    rst_n_in = 1'b1;
    for (int k = 0; k < 32; k++) begin
      m_val[k] = 32'd0;
      m_lab[k] = 5'd0;
    end

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rdy_in     = ($urandom_range(9) != 0);
      dec_en     = ($urandom_range(1) != 0);
      dec_rd     = 5'($urandom_range(31));
      dec_tag    = 5'($urandom_range(16, 1));
      commit_en  = ($urandom_range(1) != 0);
      commit_rd  = 5'($urandom_range(31));
      commit_res = $urandom;
      commit_lab = ($urandom_range(1) != 0) ? m_lab[commit_rd] : 5'($urandom_range(16));
      flush_in   = ($urandom_range(19) == 0);
      rs1        = ($urandom_range(3) == 0) ? commit_rd : 5'($urandom_range(31));
      rs2        = ($urandom_range(3) == 0) ? dec_rd : 5'($urandom_range(31));
      sb.push_back(model_read());
      #1 check_out($sformatf("rand%0d", n));
      model_edge();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
